pmod_acl2_spi_regseq: RTL

- Register-access sequencer that drives the system side of the generic solo SPI driver (spi_sysdrv role) for the ADXL362 accelerometer on the PMOD ACL2.
- Converts one register command (single-byte write, or burst read of 1..15 bytes) into driver operations:
  - TX FIFO loading, then lengths plus go_stand pulse;
  - waiting on spi_idle;
  - RX FIFO draining into a byte stream.
- Sits between the ACL2 control FSM (upstream) and the SPI solo driver (downstream).

---
 rtl/pmod_acl2_spi_regseq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pmod_acl2_spi_regseq.sv
// pmod_acl2_spi_regseq: turns ADXL362 register commands into SPI solo driver FIFO/go operations
module pmod_acl2_spi_regseq #(
  parameter int parm_tx_len_bits   = 11,
  parameter int parm_wait_cyc_bits = 2,
  parameter int parm_rx_len_bits   = 11,
  parameter int parm_timeout_cyc   = 65535
) (
  input  logic                          i_clk_20mhz,
  input  logic                          i_rst_20mhz,
  input  logic                          i_cmd_start,
  input  logic                          i_cmd_write,
  input  logic [7:0]                    i_reg_addr,
  input  logic [7:0]                    i_wr_data,
  input  logic [3:0]                    i_rd_count,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic [7:0]                    o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_go_stand,
  input  logic                          i_spi_idle,
  output logic [parm_tx_len_bits-1:0]   o_tx_len,
  output logic [parm_wait_cyc_bits-1:0] o_wait_cyc,
  output logic [parm_rx_len_bits-1:0]   o_rx_len,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_enqueue,
  input  logic                          i_tx_ready,
  input  logic [7:0]                    i_rx_data,
  output logic                          o_rx_dequeue,
  input  logic                          i_rx_valid,
  input  logic                          i_rx_avail
);
  localparam int tw = $clog2(parm_timeout_cyc + 1);
  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, LOAD_CMD, LOAD_ADDR, LOAD_DATA, GO, WAIT_BUSY, WAIT_DONE, DRAIN, DONE
  } state_t;
  state_t state;
  logic wr, pend, loading, counted, tmo;
  logic [7:0] addr, wdata;
  logic [3:0] rem;
  logic [tw-1:0] tcnt;
  always_comb begin
    loading = state inside {LOAD_CMD, LOAD_ADDR, LOAD_DATA};
    counted = loading || state inside {WAIT_RDY, WAIT_BUSY, WAIT_DONE, DRAIN};
    tmo = counted && tcnt == tw'(parm_timeout_cyc);
  end
  // FIFO strobes are gated by the same-cycle handshake inputs, so they cannot be registered
  assign o_tx_enqueue = loading && i_tx_ready && !tmo;
  assign o_rx_dequeue = state == DRAIN && i_rx_avail && !pend && rem != 4'd0 && !tmo;
  assign o_wait_cyc = '0;
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state <= IDLE;
      tcnt <= '0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rem <= '0;
      pend <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
      o_rd_data <= '0;
      o_rd_valid <= 1'b0;
      o_go_stand <= 1'b0;
      o_tx_len <= '0;
      o_rx_len <= '0;
      o_tx_data <= '0;
    end else begin
      o_done <= 1'b0;
      o_err <= 1'b0;
      o_rd_valid <= 1'b0;
      o_go_stand <= 1'b0;
      tcnt <= counted ? tcnt + 1'b1 : '0;
      if (tmo) begin
        state <= IDLE;
        tcnt <= '0;
        pend <= 1'b0;
        o_busy <= 1'b0;
        o_err <= 1'b1;
        o_tx_len <= '0;
        o_rx_len <= '0;
        o_tx_data <= '0;
      end else begin
        case (state)
          IDLE: if (i_cmd_start) begin
            if (!i_cmd_write && i_rd_count == 4'd0) o_err <= 1'b1;
            else begin
              wr <= i_cmd_write;
              addr <= i_reg_addr;
              wdata <= i_wr_data;
              rem <= i_rd_count;
              o_busy <= 1'b1;
              state <= WAIT_RDY;
            end
          end
          WAIT_RDY: if (i_spi_idle) begin
            state <= LOAD_CMD;
            tcnt <= '0;
            o_tx_len <= wr ? parm_tx_len_bits'(3) : parm_tx_len_bits'(2);
            o_rx_len <= wr ? '0 : parm_rx_len_bits'(rem);
            o_tx_data <= wr ? 8'h0A : 8'h0B;
          end
          LOAD_CMD: if (i_tx_ready) begin
            state <= LOAD_ADDR;
            tcnt <= '0;
            o_tx_data <= addr;
          end
          LOAD_ADDR: if (i_tx_ready) begin
            state <= wr ? LOAD_DATA : GO;
            tcnt <= '0;
            o_tx_data <= wr ? wdata : 8'h00;
            o_go_stand <= !wr;
          end
          LOAD_DATA: if (i_tx_ready) begin
            state <= GO;
            tcnt <= '0;
            o_tx_data <= 8'h00;
            o_go_stand <= 1'b1;
          end
          GO: state <= WAIT_BUSY;
          WAIT_BUSY: if (!i_spi_idle) begin
            state <= WAIT_DONE;
            tcnt <= '0;
          end
          WAIT_DONE: if (i_spi_idle) begin
            state <= wr ? DONE : DRAIN;
            tcnt <= '0;
            o_done <= wr;
          end
          DRAIN: if (rem == 4'd0) begin
            state <= DONE;
            tcnt <= '0;
            o_done <= 1'b1;
          end else begin
            if (o_rx_dequeue) pend <= 1'b1;
            if (i_rx_valid && pend) begin
              o_rd_data <= i_rx_data;
              o_rd_valid <= 1'b1;
              pend <= 1'b0;
              rem <= rem - 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            o_busy <= 1'b0;
            o_tx_len <= '0;
            o_rx_len <= '0;
            o_tx_data <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
